// File: rtl/audio_sample_fetcher.sv
// audio_sample_fetcher: Avalon-MM read master that streams a window of stereo PCM words from sample RAM
// through a small FIFO to a valid/ready sink. Define AUDIO_SAMPLE_FETCHER_UNDERRUN_CNT_EN for the underrun counter.
module audio_sample_fetcher #(
    parameter int ADDR_W       = 12,
    parameter int FIFO_DEPTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [3:0]        ram_byteenable,
    input  logic [31:0]       ram_readdata,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic [15:0]       smp_left,
    output logic [15:0]       smp_right
`ifdef AUDIO_SAMPLE_FETCHER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_count
`endif
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FLUSH} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     num_q;
    logic [ADDR_W:0]     idx_q;
    logic                loop_q;
    logic                busy_q;
    logic                done_q;
    logic [READ_LATENCY-1:0] pipe_q;
    logic [31:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;

    logic                accept_start;
    logic                flush_now;
    logic                credit_ok;
    logic                issue;
    logic                last_idx;
    logic                push;
    logic                pop;
    logic [CNT_W-1:0]    inflight;
    logic [ADDR_W-1:0]   rd_addr;

    // NOTE: every always_comb output gets a default before the loop, so no latch can be inferred.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CNT_W'(pipe_q[i]);
        end
    end

    // The first word is read in the accepting cycle so the sink sees data two cycles after start.
    assign accept_start = (state_q == IDLE) && start && !stop;
    assign flush_now    = ((state_q == FETCH) || (state_q == DRAIN)) && stop;
    assign credit_ok    = ({1'b0, count_q} + {1'b0, inflight}) < DEPTH_C;
    assign issue        = (accept_start && (num_words != '0))
                       || ((state_q == FETCH) && !stop && credit_ok);
    assign rd_addr      = (state_q == IDLE) ? base_addr : base_q + idx_q[ADDR_W-1:0];
    assign last_idx     = (idx_q == num_q - ONE_W);

    assign push = pipe_q[READ_LATENCY-1] && (state_q != FLUSH) && !flush_now;
    assign pop  = smp_valid && smp_ready;

    // Strobe and address follow start combinationally, so they are forced low while reset is held.
    assign ram_chipselect        = issue && !reset;
    assign ram_address           = ram_chipselect ? rd_addr : '0;
    assign ram_write             = 1'b0;
    assign ram_byteenable        = reset ? 4'h0 : 4'hF;
    assign smp_valid             = (count_q != '0);
    assign {smp_left, smp_right} = mem_q[rd_ptr_q];
    assign busy                  = busy_q;
    assign done                  = done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= (pipe_q << 1) | READ_LATENCY'(issue);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the storage is reset too, so the head outputs read zero out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_now) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= ram_readdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: clocked blocks use only non-blocking assignments, so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            loop_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_start) begin
                        base_q <= base_addr;
                        num_q  <= num_words;
                        loop_q <= loop_en;
                        idx_q  <= '0;
                        if (num_words == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q <= 1'b1;
                            if (num_words == ONE_W) begin
                                state_q <= loop_en ? FETCH : DRAIN;
                            end else begin
                                idx_q   <= ONE_W;
                                state_q <= FETCH;
                            end
                        end
                    end
                end
                FETCH: begin
                    if (stop) begin
                        state_q <= FLUSH;
                    end else if (issue) begin
                        if (last_idx) begin
                            idx_q <= '0;
                            if (!loop_q) begin
                                state_q <= DRAIN;
                            end
                        end else begin
                            idx_q <= idx_q + ONE_W;
                        end
                    end
                end
                DRAIN: begin
                    if (stop) begin
                        state_q <= FLUSH;
                    end else if ((inflight == '0) && (count_q == '0)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                FLUSH: begin
                    if (inflight == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The credit rule makes a push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && !pop && ({1'b0, count_q} == DEPTH_C)));
        end
    end

`ifdef AUDIO_SAMPLE_FETCHER_UNDERRUN_CNT_EN
    logic [15:0] underrun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_q <= '0;
        end else if (accept_start) begin
            underrun_q <= '0;
        end else if ((state_q == FETCH) && smp_ready && !smp_valid && (underrun_q != 16'hFFFF)) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end

    assign underrun_count = underrun_q;
`endif

endmodule

// File: tb/tb_audio_sample_fetcher.sv
// tb_audio_sample_fetcher: table-driven, hand-written and randomized checks of audio_sample_fetcher
// against a window model (address = (base + i) mod 4096, sample = RAM[address]).
module tb_audio_sample_fetcher;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 8;
    localparam int BUDGET = 20000;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic              loop_en;
    logic              smp_ready;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   num_words;
    logic              busy;
    logic              done;
    logic              ram_chipselect;
    logic              ram_write;
    logic              smp_valid;
    logic [ADDR_W-1:0] ram_address;
    logic [3:0]        ram_byteenable;
    logic [31:0]       ram_readdata;
    logic [15:0]       smp_left;
    logic [15:0]       smp_right;
`ifdef AUDIO_SAMPLE_FETCHER_UNDERRUN_CNT_EN
    logic [15:0]       underrun_count;
`endif

    audio_sample_fetcher #(
        .ADDR_W(ADDR_W),
        .FIFO_DEPTH(DEPTH),
        .READ_LATENCY(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stop(stop),
        .loop_en(loop_en),
        .base_addr(base_addr),
        .num_words(num_words),
        .busy(busy),
        .done(done),
        .ram_address(ram_address),
        .ram_chipselect(ram_chipselect),
        .ram_write(ram_write),
        .ram_byteenable(ram_byteenable),
        .ram_readdata(ram_readdata),
        .smp_valid(smp_valid),
        .smp_ready(smp_ready),
        .smp_left(smp_left),
        .smp_right(smp_right)
`ifdef AUDIO_SAMPLE_FETCHER_UNDERRUN_CNT_EN
        ,
        .underrun_count(underrun_count)
`endif
    );

    always #5 clk = ~clk;

    // Sample RAM with one cycle of read latency.
    logic [31:0] ram [4096];
    always_ff @(posedge clk) begin
        if (ram_chipselect) ram_readdata <= ram[ram_address];
    end

    logic [ADDR_W-1:0] addr_log[$];
    int                rd_cyc[$];
    logic [31:0]       smp_log[$];
    int                done_seen;
    int                busy_seen;
    int                cyc_now = 0;

    always @(negedge clk) begin
        cyc_now++;
        if (!reset) begin
            if (ram_chipselect) begin
                addr_log.push_back(ram_address);
                rd_cyc.push_back(cyc_now);
            end
            if (smp_valid && smp_ready) smp_log.push_back({smp_left, smp_right});
            if (done) done_seen++;
            if (busy) busy_seen++;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        addr_log.delete();
        rd_cyc.delete();
        smp_log.delete();
        done_seen = 0;
        busy_seen = 0;
    endtask

    function automatic logic ready_draw(input int pct);
        return int'($urandom_range(1, 100)) <= pct;
    endfunction

    function automatic logic [ADDR_W-1:0] win_addr(input logic [ADDR_W-1:0] b, input int i);
        return ADDR_W'((int'(b) + i) % 4096);
    endfunction

    // Compares logged reads and samples with the window model; exp_cnt < 0 skips the count checks.
    task automatic check_stream(input string nm, input logic [ADDR_W-1:0] b, input int n, input int exp_cnt);
        int bad_a = 0;
        int bad_s = 0;
        if (exp_cnt >= 0) begin
            check({nm, " reads"}, 64'(addr_log.size()), 64'(exp_cnt));
            check({nm, " samples"}, 64'(smp_log.size()), 64'(exp_cnt));
        end
        foreach (addr_log[i]) if (addr_log[i] !== win_addr(b, i % n)) bad_a++;
        foreach (smp_log[i]) if (smp_log[i] !== ram[win_addr(b, i % n)]) bad_s++;
        check({nm, " addr_seq_errs"}, 64'(bad_a), 64'(0));
        check({nm, " data_seq_errs"}, 64'(bad_s), 64'(0));
    endtask

    task automatic wait_done(input string nm, input int pct);
        int cyc = 0;
        while (!done && cyc < BUDGET) begin
            smp_ready = ready_draw(pct);
            tick();
            cyc++;
        end
        check({nm, " done_within_budget"}, 64'(done), 64'(1));
        smp_ready = 1'b0;
        tick();
    endtask

    task automatic kick(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n, input logic lp, input logic rdy);
        base_addr = b;
        num_words = n;
        loop_en   = lp;
        smp_ready = rdy;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic run_window(input string nm, input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n,
                              input int pct, input int exp_reads);
        clear_logs();
        kick(b, n, 1'b0, ready_draw(pct));
        wait_done(nm, pct);
        check({nm, " idle_after"}, 64'({busy, smp_valid, done}), 64'(0));
        check({nm, " done_pulses"}, 64'(done_seen), 64'(1));
        check_stream(nm, b, int'(n), exp_reads);
        if (n == '0) check({nm, " busy_never"}, 64'(busy_seen), 64'(0));
    endtask

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W:0]   num;
        int                ready_pct;
        int                exp_reads;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cyc;
        for (int i = 0; i < 4096; i++) ram[i] = $urandom();
        ram[12'h010] = 32'h11112222;
        ram[12'h011] = 32'h33334444;
        ram[12'h012] = 32'h55556666;
        ram[12'h013] = 32'h77778888;

        vecs[0] = '{12'h010, 13'd4,    100, 4};
        vecs[1] = '{12'hFFE, 13'd4,    100, 4};
        vecs[2] = '{12'h7A5, 13'd1,    100, 1};
        vecs[3] = '{12'h020, 13'd0,    100, 0};
        vecs[4] = '{12'h0C0, 13'd4096, 70,  4096};
        vecs[5] = '{12'hFF0, 13'd33,   25,  33};

        reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; smp_ready = 1'b0;
        base_addr = '0; num_words = '0;
        #12;
        check("rst ctrl {busy,done,cs,wr,valid}", 64'({busy, done, ram_chipselect, ram_write, smp_valid}), 64'(0));
        check("rst address", 64'(ram_address), 64'(0));
        check("rst byteenable", 64'(ram_byteenable), 64'(0));
        check("rst sample", 64'({smp_left, smp_right}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("byteenable after reset", 64'(ram_byteenable), 64'(4'hF));

        for (int i = 0; i < 6; i++) begin
            run_window($sformatf("vec%0d", i), vecs[i].base, vecs[i].num, vecs[i].ready_pct, vecs[i].exp_reads);
            if (i == 0) begin
                check("basic first sample", 64'(smp_log[0]), 64'(32'h11112222));
                check("basic last sample", 64'(smp_log[3]), 64'(32'h77778888));
                check("basic consecutive reads", 64'(rd_cyc[3] - rd_cyc[0]), 64'(3));
            end
            if (i == 1) check("wrap third address", 64'(addr_log[2]), 64'(12'h000));
        end

        // Backpressure: reads stop at the FIFO depth and the head is held.
        clear_logs();
        kick(12'h200, 13'd20, 1'b0, 1'b0);
        repeat (30) tick();
        check("bp reads_while_stalled", 64'(addr_log.size()), 64'(DEPTH));
        check("bp cs_low", 64'(ram_chipselect), 64'(0));
        check("bp head", 64'({smp_left, smp_right}), 64'(ram[12'h200]));
        repeat (5) tick();
        check("bp head_held", 64'({smp_left, smp_right}), 64'(ram[12'h200]));
        wait_done("bp", 100);
        check("bp done_pulses", 64'(done_seen), 64'(1));
        check_stream("bp", 12'h200, 20, 20);

        // Loop with a stop: twenty back-to-back reads, then a flush with no stray samples.
        clear_logs();
        kick(12'h100, 13'd3, 1'b1, 1'b1);
        repeat (19) tick();
        check("loop reads_in_20_cycles", 64'(addr_log.size()), 64'(20));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("loop valid_low_after_stop", 64'(smp_valid), 64'(0));
        cyc = 0;
        while (busy && cyc < BUDGET) begin
            tick();
            cyc++;
        end
        check("loop idle_within_budget", 64'(busy), 64'(0));
        repeat (5) tick();
        check("loop no_done", 64'(done_seen), 64'(0));
        check("loop samples_before_stop", 64'(smp_log.size()), 64'(19));
        check_stream("loop", 12'h100, 3, -1);

        // Start and stop together in IDLE: nothing happens.
        clear_logs();
        base_addr = 12'h040; num_words = 13'd5; loop_en = 1'b0; smp_ready = 1'b1;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        repeat (4) tick();
        check("collide {reads,busy,done}", 64'({16'(addr_log.size()), 16'(busy_seen), 16'(done_seen)}), 64'(0));

        // A second start and input changes while busy are ignored.
        clear_logs();
        kick(12'h300, 13'd10, 1'b0, 1'b1);
        repeat (2) tick();
        kick(12'h050, 13'd2, 1'b1, 1'b1);
        wait_done("restart", 100);
        check("restart done_pulses", 64'(done_seen), 64'(1));
        check_stream("restart", 12'h300, 10, 10);

        // Reset mid-operation takes effect immediately.
        clear_logs();
        kick(12'h400, 13'd50, 1'b0, 1'b0);
        repeat (5) tick();
        #2;
        reset = 1'b1;
        #1;
        check("midrst {busy,cs,valid}", 64'({busy, ram_chipselect, smp_valid}), 64'(0));
        check("midrst address", 64'(ram_address), 64'(0));
        check("midrst sample", 64'({smp_left, smp_right}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        tick();

        for (int r = 0; r < 6; r++) begin
            logic [ADDR_W-1:0] b;
            logic [ADDR_W:0]   n;
            b = ADDR_W'($urandom_range(0, 4095));
            n = (ADDR_W + 1)'($urandom_range(1, 60));
            run_window($sformatf("rnd%0d", r), b, n, int'($urandom_range(20, 100)), int'(n));
        end

`ifdef AUDIO_SAMPLE_FETCHER_UNDERRUN_CNT_EN
        clear_logs();
        kick(12'h010, 13'd4, 1'b0, 1'b1);
        check("udr cleared_on_start", 64'(underrun_count), 64'(0));
        wait_done("udr", 100);
        check("udr single_empty_cycle", 64'(underrun_count), 64'(1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_sample_fetcher.md
Name: audio_sample_fetcher

Overview:
- Avalon-MM read master that streams stereo PCM words out of the on-chip sample RAM (4096 x 32, single port) to the audio output path.
- Reads a programmed window of words, buffers them in a small FIFO and presents one stereo sample per valid/ready handshake to the downstream DAC/I2S serializer.
- Sits directly downstream of the sample RAM, on the RAM's second slave port; the CPU loads the RAM through the first port.

Parameters:
- ADDR_W, 12, RAM word-address width; window addresses wrap modulo 2^ADDR_W.
- FIFO_DEPTH, 8, sample FIFO entries; power of two, >= READ_LATENCY+1.
- READ_LATENCY, 1, cycles from ram_chipselect/ram_address to valid ram_readdata.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins playback when idle.
- stop  in  1  one-cycle pulse; aborts playback.
- loop_en  in  1  sampled at start; 1 = restart at base_addr after the last word.
- base_addr  in  ADDR_W  first word address; sampled at start.
- num_words  in  ADDR_W+1  window length in words, 0..4096; sampled at start.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse on normal (non-loop) completion.
- ram_address  out  ADDR_W  RAM word address.
- ram_chipselect  out  1  read strobe; one word is read per cycle it is high.
- ram_write  out  1  constant 0.
- ram_byteenable  out  4  constant 4'hF.
- ram_readdata  in  32  RAM read data.
- smp_valid  out  1  FIFO non-empty.
- smp_ready  in  1  downstream accepts the sample.
- smp_left  out  16  FIFO head bits [31:16].
- smp_right  out  16  FIFO head bits [15:0].

Behaviour:
- Reset: state IDLE; FIFO emptied; in-flight count 0. busy, done, ram_chipselect, ram_write and smp_valid are 0. ram_address, ram_byteenable, smp_left and smp_right are 0; ram_byteenable is 4'hF once reset is released.
- FSM states: IDLE, FETCH, DRAIN, FLUSH.
- IDLE:
  - On start, latch base_addr, num_words and loop_en; set index = 0.
  - If num_words == 0, pulse done in the next cycle and stay in IDLE; busy is never raised.
  - Otherwise go to FETCH.
  - If start and stop arrive in the same cycle, stop wins and start is ignored.
- FETCH:
  - Issue a read (ram_chipselect = 1, ram_address = (base + index) mod 2^ADDR_W) in any cycle where fifo_count + inflight < FIFO_DEPTH.
  - After a read of index num_words-1: with loop_en, set index = 0 and continue issuing without a gap cycle; without loop_en, go to DRAIN.
- Data return: ram_readdata is captured into the FIFO exactly READ_LATENCY cycles after each issue. A shift register of issue flags tracks in-flight reads, so back-to-back reads are supported and return at full rate.
- FIFO:
  - Push and pop in the same cycle is legal; count is unchanged.
  - The credit rule guarantees no overflow. If an overflow were ever to occur, it is a design assertion failure.
- Output: smp_valid = (fifo_count != 0). A pop occurs on smp_valid & smp_ready. smp_left and smp_right always reflect the FIFO head and are held while smp_ready is low.
- DRAIN: no new reads. When inflight == 0 and the FIFO is empty, pulse done, drop busy and go to IDLE.
- stop in FETCH or DRAIN:
  - Go to FLUSH, stop issuing and empty the FIFO immediately; smp_valid falls the next cycle.
  - Data still in flight is discarded on return.
  - Leave FLUSH when inflight == 0, then go to IDLE. done is not pulsed.
- start while busy is ignored.
- Changes to base_addr, num_words or loop_en while busy have no effect.
- Reset mid-operation returns every signal to its reset value immediately.

Optional Feature:
- Macro: AUDIO_SAMPLE_FETCHER_UNDERRUN_CNT_EN.
- With the macro defined:
  - Adds output port underrun_count (16 bits).
  - The counter increments in each FETCH-state cycle where smp_ready = 1 and smp_valid = 0, and saturates at 16'hFFFF.
  - It is cleared on reset and on each accepted start.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic playback: RAM[0x010..0x013] = 0x11112222, 0x33334444, 0x55556666, 0x77778888; start with base 0x010, num 4, loop 0, smp_ready = 1 → four reads on consecutive cycles. Expected samples (L,R) in order: (1111,2222), (3333,4444), (5555,6666), (7777,8888). done pulses once, busy falls.
- Address wrap: base 0xFFE, num 4 → ram_address sequence 0xFFE, 0xFFF, 0x000, 0x001. Four samples are delivered in that order.
- Backpressure: smp_ready = 0, num 20 → ram_chipselect is high for exactly 8 reads, then low; smp_left/smp_right are held. Raise smp_ready → all 20 samples arrive in order with no loss or duplication.
- Loop: base 0x100, num 3, loop 1 → address pattern 0x100, 0x101, 0x102, 0x100, … with no idle read cycle at the wrap. done never pulses. A stop pulse leads to IDLE with smp_valid = 0 the next cycle and no spurious samples.
- Zero length and collisions: start with num 0 → done pulses, busy stays 0, no reads. start and stop in the same IDLE cycle → nothing happens. A second start during playback → ignored.
- Underrun counter (macro on): num 4, smp_ready = 1 held from start → underrun_count = 1 from the single first empty FETCH cycle. Forcing ram_chipselect starvation by delaying start data gives the expected incremented count. A further start clears it to 0.
